// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor
// Tracks the output of an external 4-bit ripple down-counter that is
// asynchronous to clk. Each accepted sample is classified against the last
// accepted value: hold, +/-1 step (mod 16), wrap (0<->15 step) or jump.
// Wraps are counted in a saturating counter and compared against a threshold
// to produce a registered alarm.
//
// Build option:
//   RCM_GLITCH_FILTER_EN  defined   -> a sample is accepted only when the
//                                      synchronized value has been stable for
//                                      two consecutive cycles (latency 4).
//                         undefined -> every synchronized value is accepted
//                                      (latency 3).
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   cnt_in      in   [3:0] raw ripple-counter value (async, may glitch)
//   clear       in   synchronous clear of tracking and statistics
//   thresh      in   [WRAP_W-1:0] alarm threshold for wrap_count
//   cnt_sync    out  [3:0] last accepted count value
//   cnt_valid   out  cnt_sync holds an accepted sample
//   step_pulse  out  one-cycle pulse on an accepted +/-1 step
//   dir         out  direction of last step (1 = down, 0 = up)
//   wrap_pulse  out  one-cycle pulse on a 0->15 or 15->0 step
//   jump_err    out  one-cycle pulse on a non-adjacent accepted sample
//   wrap_count  out  [WRAP_W-1:0] saturating count of wraps
//   alarm       out  registered (wrap_count >= thresh)
//
// State table:
//   ST_INIT  | no accepted sample yet; next accepted sample loads cnt_sync
//   ST_TRACK | cnt_sync valid; accepted samples are classified

module ripple_count_monitor #(
    parameter int unsigned WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cnt_in,
    input  logic              clear,
    input  logic [WRAP_W-1:0] thresh,
    output logic [3:0]        cnt_sync,
    output logic              cnt_valid,
    output logic              step_pulse,
    output logic              dir,
    output logic              wrap_pulse,
    output logic              jump_err,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              alarm
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [3:0]        s1_q, s2_q;
    // Valid bits travel alongside the synchronizer so the zeros left by
    // reset are never mistaken for a real counter value.
    logic              v1_q, v2_q;
    logic              sample_ok;

    logic [3:0]        cnt_sync_q, cnt_sync_d;
    logic              dir_q, dir_d;
    logic              step_q, step_d;
    logic              wrap_q, wrap_d;
    logic              jump_q, jump_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              alarm_q, alarm_d;

    logic [3:0]        delta;
    logic              is_up, is_dn, is_wrap;

    // Two-flop synchronizer for the asynchronous counter bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 4'd0;
            s2_q <= 4'd0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            s1_q <= cnt_in;
            s2_q <= s1_q;
            v1_q <= 1'b1;
            v2_q <= v1_q;
        end
    end

`ifdef RCM_GLITCH_FILTER_EN
    logic [3:0] filt_q;
    logic       filt_v_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q   <= 4'd0;
            filt_v_q <= 1'b0;
        end else begin
            filt_q   <= s2_q;
            filt_v_q <= v2_q;
        end
    end

    // A ripple glitch lasts less than one sample period, so requiring two
    // equal synchronized values in a row rejects it.
    assign sample_ok = v2_q & filt_v_q & (s2_q == filt_q);
`else
    assign sample_ok = v2_q;
`endif

    // Modular difference: 1 is an up step, 15 (-1) is a down step.
    assign delta   = s2_q - cnt_sync_q;
    assign is_up   = (delta == 4'd1);
    assign is_dn   = (delta == 4'd15);
    assign is_wrap = (is_dn && (cnt_sync_q == 4'd0)) ||
                     (is_up && (cnt_sync_q == 4'd15));

    always_comb begin
        state_d    = state_q;
        cnt_sync_d = cnt_sync_q;
        dir_d      = dir_q;
        step_d     = 1'b0;
        wrap_d     = 1'b0;
        jump_d     = 1'b0;
        wrap_cnt_d = wrap_cnt_q;

        if (clear) begin
            // Clear wins over any sample arriving in the same cycle.
            state_d    = ST_INIT;
            cnt_sync_d = 4'd0;
            dir_d      = 1'b0;
            wrap_cnt_d = '0;
        end else if (sample_ok) begin
            case (state_q)
                ST_INIT: begin
                    cnt_sync_d = s2_q;
                    state_d    = ST_TRACK;
                end
                ST_TRACK: begin
                    if (delta == 4'd0) begin
                        cnt_sync_d = cnt_sync_q;
                    end else if (is_up || is_dn) begin
                        cnt_sync_d = s2_q;
                        step_d     = 1'b1;
                        dir_d      = is_dn;
                        if (is_wrap) begin
                            wrap_d = 1'b1;
                            if (wrap_cnt_q != {WRAP_W{1'b1}}) begin
                                wrap_cnt_d = wrap_cnt_q + {{(WRAP_W-1){1'b0}}, 1'b1};
                            end
                        end
                    end else begin
                        cnt_sync_d = s2_q;
                        jump_d     = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    // Alarm looks at the registered count, so it trails wrap_count by a cycle.
    assign alarm_d = (wrap_cnt_q >= thresh);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            cnt_sync_q <= 4'd0;
            dir_q      <= 1'b0;
            step_q     <= 1'b0;
            wrap_q     <= 1'b0;
            jump_q     <= 1'b0;
            wrap_cnt_q <= '0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_sync_q <= cnt_sync_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            wrap_q     <= wrap_d;
            jump_q     <= jump_d;
            wrap_cnt_q <= wrap_cnt_d;
            alarm_q    <= alarm_d;
        end
    end

    assign cnt_sync   = cnt_sync_q;
    assign cnt_valid  = (state_q == ST_TRACK);
    assign step_pulse = step_q;
    assign dir        = dir_q;
    assign wrap_pulse = wrap_q;
    assign jump_err   = jump_q;
    assign wrap_count = wrap_cnt_q;
    assign alarm      = alarm_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
module tb_ripple_count_monitor;

`ifdef RCM_GLITCH_FILTER_EN
    localparam int LAT = 4;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit FILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] cnt_in = 4'd0;
    logic       clear = 1'b0;
    logic [7:0] thresh = 8'd2;
    logic [3:0] thresh4 = 4'd2;

    logic [3:0] cnt_sync;
    logic       cnt_valid, step_pulse, dir, wrap_pulse, jump_err, alarm;
    logic [7:0] wrap_count;

    logic [3:0] cnt_sync4;
    logic       cnt_valid4, step_pulse4, dir4, wrap_pulse4, jump_err4, alarm4;
    logic [3:0] wrap_count4;

    int total = 0;
    int bad = 0;

    int n_step = 0, n_step_dn = 0, n_wrap = 0, n_jump = 0, n_chg = 0;
    logic [3:0] prev_sync = 4'd0;
    logic [3:0] last_wrap_val = 4'd0;
    logic [3:0] last_jump_val = 4'd0;

    int s0, d0, w0, j0, c0;

    ripple_count_monitor #(.WRAP_W(8)) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .clear(clear), .thresh(thresh),
        .cnt_sync(cnt_sync), .cnt_valid(cnt_valid), .step_pulse(step_pulse),
        .dir(dir), .wrap_pulse(wrap_pulse), .jump_err(jump_err),
        .wrap_count(wrap_count), .alarm(alarm)
    );

    ripple_count_monitor #(.WRAP_W(4)) dut4 (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .clear(clear), .thresh(thresh4),
        .cnt_sync(cnt_sync4), .cnt_valid(cnt_valid4), .step_pulse(step_pulse4),
        .dir(dir4), .wrap_pulse(wrap_pulse4), .jump_err(jump_err4),
        .wrap_count(wrap_count4), .alarm(alarm4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step_pulse) n_step <= n_step + 1;
        if (step_pulse && dir) n_step_dn <= n_step_dn + 1;
        if (wrap_pulse) begin
            n_wrap <= n_wrap + 1;
            last_wrap_val <= cnt_sync;
        end
        if (jump_err) begin
            n_jump <= n_jump + 1;
            last_jump_val <= cnt_sync;
        end
        if (cnt_sync != prev_sync) n_chg <= n_chg + 1;
        prev_sync <= cnt_sync;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cnt_in = 4'd9;
        thresh = 8'd2;
        tick(2);
        total++;
        if ({cnt_sync, cnt_valid, step_pulse, dir, wrap_pulse, jump_err, wrap_count, alarm} !== 18'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {cnt_sync, cnt_valid, step_pulse, dir, wrap_pulse, jump_err, wrap_count, alarm});
        end
        total++;
        if ({cnt_sync4, cnt_valid4, step_pulse4, dir4, wrap_pulse4, jump_err4, wrap_count4, alarm4} !== 14'd0) begin
            bad++;
            $display("FAIL reset_outputs_w4 got=%h exp=0",
                     {cnt_sync4, cnt_valid4, step_pulse4, dir4, wrap_pulse4, jump_err4, wrap_count4, alarm4});
        end
        rst = 1'b1;
        tick(LAT - 1);
        total++;
        if (cnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_sample_early got=%0b exp=0", cnt_valid);
        end
        tick(1);
        total++;
        if ({cnt_valid, cnt_sync} !== {1'b1, 4'd9}) begin
            bad++;
            $display("FAIL first_sample_load got valid=%0b sync=%0d exp valid=1 sync=9", cnt_valid, cnt_sync);
        end
        total++;
        if ({step_pulse, wrap_pulse, jump_err} !== 3'b000 || wrap_count !== 8'd0) begin
            bad++;
            $display("FAIL first_sample_pulses got=%b wc=%0d exp=000 wc=0",
                     {step_pulse, wrap_pulse, jump_err}, wrap_count);
        end
    endtask

    task automatic test_down_steps();
        s0 = n_step; d0 = n_step_dn; w0 = n_wrap; j0 = n_jump;
        for (int k = 0; k < 10; k++) begin
            cnt_in = 4'(8 - k);
            tick(6);
        end
        tick(LAT);
        total++;
        if (n_step - s0 !== 10 || n_step_dn - d0 !== 10) begin
            bad++;
            $display("FAIL down_steps got steps=%0d down=%0d exp 10/10", n_step - s0, n_step_dn - d0);
        end
        total++;
        if (n_wrap - w0 !== 1 || last_wrap_val !== 4'd15) begin
            bad++;
            $display("FAIL down_wrap got wraps=%0d at=%0d exp 1 at 15", n_wrap - w0, last_wrap_val);
        end
        total++;
        if (n_jump - j0 !== 0) begin
            bad++;
            $display("FAIL down_jumps got=%0d exp=0", n_jump - j0);
        end
        total++;
        if ({cnt_sync, dir, wrap_count, alarm} !== {4'd15, 1'b1, 8'd1, 1'b0}) begin
            bad++;
            $display("FAIL down_final got sync=%0d dir=%0b wc=%0d alarm=%0b exp 15/1/1/0",
                     cnt_sync, dir, wrap_count, alarm);
        end
    endtask

    task automatic test_wrap_saturate();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(LAT + 1);
        total++;
        if ({cnt_valid, cnt_sync, wrap_count} !== {1'b1, 4'd15, 8'd0}) begin
            bad++;
            $display("FAIL clear_reload got valid=%0b sync=%0d wc=%0d exp 1/15/0", cnt_valid, cnt_sync, wrap_count);
        end
        s0 = n_step; w0 = n_wrap; j0 = n_jump;
        for (int c = 0; c < 17; c++) begin
            for (int k = 1; k <= 16; k++) begin
                cnt_in = 4'(15 - k);
                tick(3);
            end
            if (c == 0) begin
                tick(LAT);
                total++;
                if ({wrap_count, alarm} !== {8'd1, 1'b0}) begin
                    bad++;
                    $display("FAIL wrap_one got wc=%0d alarm=%0b exp 1/0", wrap_count, alarm);
                end
            end
            if (c == 1) begin
                tick(LAT);
                total++;
                if ({wrap_count, alarm} !== {8'd2, 1'b1}) begin
                    bad++;
                    $display("FAIL wrap_two got wc=%0d alarm=%0b exp 2/1", wrap_count, alarm);
                end
            end
        end
        tick(LAT);
        total++;
        if ({wrap_count, alarm} !== {8'd17, 1'b1}) begin
            bad++;
            $display("FAIL wrap_17 got wc=%0d alarm=%0b exp 17/1", wrap_count, alarm);
        end
        total++;
        if ({wrap_count4, alarm4} !== {4'd15, 1'b1}) begin
            bad++;
            $display("FAIL wrap_sat_w4 got wc=%0d alarm=%0b exp 15/1", wrap_count4, alarm4);
        end
        total++;
        if (n_wrap - w0 !== 17 || n_step - s0 !== 272 || n_jump - j0 !== 0) begin
            bad++;
            $display("FAIL wrap_pulses got wraps=%0d steps=%0d jumps=%0d exp 17/272/0",
                     n_wrap - w0, n_step - s0, n_jump - j0);
        end
    endtask

    task automatic test_alarm_thresh();
        thresh = 8'd20;
        tick(1);
        total++;
        if (alarm !== 1'b0) begin
            bad++;
            $display("FAIL alarm_thr20 got=%0b exp=0", alarm);
        end
        thresh = 8'd17;
        #2;
        total++;
        if (alarm !== 1'b0) begin
            bad++;
            $display("FAIL alarm_registered got=%0b exp=0", alarm);
        end
        tick(1);
        total++;
        if (alarm !== 1'b1) begin
            bad++;
            $display("FAIL alarm_thr17 got=%0b exp=1", alarm);
        end
        thresh = 8'd18;
        tick(1);
        total++;
        if (alarm !== 1'b0) begin
            bad++;
            $display("FAIL alarm_thr18 got=%0b exp=0", alarm);
        end
        thresh = 8'd2;
        tick(1);
    endtask

    task automatic test_clear_priority();
        for (int k = 1; k <= 15; k++) begin
            cnt_in = 4'(15 - k);
            tick(3);
        end
        tick(LAT);
        total++;
        if (cnt_sync !== 4'd0) begin
            bad++;
            $display("FAIL clr_setup got sync=%0d exp=0", cnt_sync);
        end
        w0 = n_wrap;
        cnt_in = 4'd15;
        tick(LAT - 1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        total++;
        if ({wrap_count, cnt_valid, wrap_pulse, cnt_sync, dir} !== {8'd0, 1'b0, 1'b0, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL clear_prio got wc=%0d valid=%0b wrap=%0b sync=%0d dir=%0b exp 0/0/0/0/0",
                     wrap_count, cnt_valid, wrap_pulse, cnt_sync, dir);
        end
        tick(1);
        total++;
        if ({cnt_valid, cnt_sync, wrap_count, wrap_pulse, step_pulse} !== {1'b1, 4'd15, 8'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL clear_relearn got valid=%0b sync=%0d wc=%0d wrap=%0b step=%0b exp 1/15/0/0/0",
                     cnt_valid, cnt_sync, wrap_count, wrap_pulse, step_pulse);
        end
        tick(1);
        total++;
        if (n_wrap - w0 !== 0) begin
            bad++;
            $display("FAIL clear_no_wrap got=%0d exp=0", n_wrap - w0);
        end
    endtask

    task automatic test_jump();
        logic [3:0] seq [8];
        seq = '{4'd0, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        w0 = n_wrap; d0 = n_step_dn;
        for (int k = 0; k < 8; k++) begin
            cnt_in = seq[k];
            tick(4);
        end
        tick(LAT);
        total++;
        if ({cnt_sync, wrap_count, dir} !== {4'd5, 8'd3, 1'b0} || n_wrap - w0 !== 3 || n_step_dn - d0 !== 1) begin
            bad++;
            $display("FAIL up_wraps got sync=%0d wc=%0d dir=%0b wraps=%0d dn=%0d exp 5/3/0/3/1",
                     cnt_sync, wrap_count, dir, n_wrap - w0, n_step_dn - d0);
        end
        s0 = n_step; w0 = n_wrap; j0 = n_jump;
        cnt_in = 4'd12;
        tick(4 + LAT);
        total++;
        if (n_jump - j0 !== 1 || last_jump_val !== 4'd12) begin
            bad++;
            $display("FAIL jump_pulse got jumps=%0d at=%0d exp 1 at 12", n_jump - j0, last_jump_val);
        end
        total++;
        if ({cnt_sync, wrap_count, dir} !== {4'd12, 8'd3, 1'b0} || n_step - s0 !== 0 || n_wrap - w0 !== 0) begin
            bad++;
            $display("FAIL jump_side got sync=%0d wc=%0d dir=%0b steps=%0d wraps=%0d exp 12/3/0/0/0",
                     cnt_sync, wrap_count, dir, n_step - s0, n_wrap - w0);
        end
    endtask

    task automatic test_glitch();
        cnt_in = 4'd8;
        tick(4 + LAT);
        s0 = n_step; j0 = n_jump; c0 = n_chg;
        cnt_in = 4'd11;
        tick(1);
        cnt_in = 4'd8;
        tick(4 + LAT);
        if (FILT) begin
            total++;
            if (n_jump - j0 !== 0 || n_chg - c0 !== 0 || n_step - s0 !== 0 || cnt_sync !== 4'd8) begin
                bad++;
                $display("FAIL glitch_filtered got jumps=%0d chg=%0d steps=%0d sync=%0d exp 0/0/0/8",
                         n_jump - j0, n_chg - c0, n_step - s0, cnt_sync);
            end
        end else begin
            total++;
            if (n_jump - j0 !== 2 || n_chg - c0 !== 2 || n_step - s0 !== 0 || cnt_sync !== 4'd8) begin
                bad++;
                $display("FAIL glitch_unfiltered got jumps=%0d chg=%0d steps=%0d sync=%0d exp 2/2/0/8",
                         n_jump - j0, n_chg - c0, n_step - s0, cnt_sync);
            end
        end
    endtask

    task automatic test_reset_mid();
        total++;
        if ({alarm, wrap_count4} !== {1'b1, 4'd3}) begin
            bad++;
            $display("FAIL premid_state got alarm=%0b wc4=%0d exp 1/3", alarm, wrap_count4);
        end
        #3;
        rst = 1'b0;
        #1;
        total++;
        if ({cnt_sync, cnt_valid, step_pulse, dir, wrap_pulse, jump_err, wrap_count, alarm} !== 18'd0) begin
            bad++;
            $display("FAIL midrun_reset got=%h exp=0",
                     {cnt_sync, cnt_valid, step_pulse, dir, wrap_pulse, jump_err, wrap_count, alarm});
        end
        thresh = 8'd0;
        thresh4 = 4'd0;
        tick(1);
        total++;
        if (alarm !== 1'b0) begin
            bad++;
            $display("FAIL reset_holds_alarm got=%0b exp=0", alarm);
        end
        j0 = n_jump; s0 = n_step;
        rst = 1'b1;
        tick(1);
        total++;
        if ({alarm, alarm4, cnt_valid} !== 3'b110) begin
            bad++;
            $display("FAIL thr0_alarm got alarm=%0b alarm4=%0b valid=%0b exp 1/1/0", alarm, alarm4, cnt_valid);
        end
        tick(LAT - 2);
        total++;
        if (cnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_sync_discard got valid=%0b exp=0", cnt_valid);
        end
        tick(1);
        total++;
        if ({cnt_valid, cnt_sync} !== {1'b1, 4'd8}) begin
            bad++;
            $display("FAIL mid_relearn got valid=%0b sync=%0d exp 1/8", cnt_valid, cnt_sync);
        end
        tick(2);
        total++;
        if (n_jump - j0 !== 0 || n_step - s0 !== 0) begin
            bad++;
            $display("FAIL mid_relearn_pulses got jumps=%0d steps=%0d exp 0/0", n_jump - j0, n_step - s0);
        end
    endtask

    initial begin
        test_reset();
        test_down_steps();
        test_wrap_saturate();
        test_alarm_thresh();
        test_clear_priority();
        test_jump();
        test_glitch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
